// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter
//
// Round-robin arbiter sharing the two ports of a single-clock true dual-port
// RAM among N_REQ requesters. Each cycle up to two requests are granted: the
// first winner of the round-robin scan drives port A and the second drives
// port B. A port B candidate that hits the same address as winner A is held
// off when either side writes; two reads of one address both go through.
// Each port's registered RAM output is routed back to the requester that was
// granted on that port, one cycle after the grant.
//
// Ports:
//   clk, rst_n                 single clock, asynchronous active-low reset
//   req_valid/we/addr/wdata    per-requester request fields, packed by index
//   req_ready                  combinational grant, one bit per requester
//   rsp_valid/rsp_rdata        one-cycle response strobe and data per requester
//   ram_addr/data/we_a/_b      RAM port drive (all zero when port is idle)
//   ram_q_a, ram_q_b           RAM registered outputs (write-through)

module dpram_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned N_REQ      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [N_REQ*DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0]       ram_addr_a,
  output logic [ADDR_WIDTH-1:0]       ram_addr_b,
  output logic [DATA_WIDTH-1:0]       ram_data_a,
  output logic [DATA_WIDTH-1:0]       ram_data_b,
  output logic                        ram_we_a,
  output logic                        ram_we_b,
  input  logic [DATA_WIDTH-1:0]       ram_q_a,
  input  logic [DATA_WIDTH-1:0]       ram_q_b
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef logic [IDX_W-1:0] idx_t;

  // Successor index in the circular order, wrapping N_REQ-1 back to 0.
  function automatic idx_t next_idx(input idx_t idx);
    if (32'(idx) == N_REQ - 1) begin
      return '0;
    end
    return idx + idx_t'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Unpacked views of the packed request buses
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] addr_arr  [N_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  idx_t ptr_q, ptr_d;
  logic rv_a_q, rv_b_q;
  idx_t own_a_q, own_b_q;

  // ---------------------------------------------------------------------------
  // Round-robin scan starting at ptr
  // ---------------------------------------------------------------------------
  logic found_a, found_b;
  idx_t idx_a, idx_b;

  always_comb begin
    int unsigned s;
    idx_t        cand;
    found_a = 1'b0;
    found_b = 1'b0;
    idx_a   = '0;
    idx_b   = '0;
    s       = 0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      s = 32'(ptr_q) + 32'(k);
      if (s >= N_REQ) begin
        s = s - N_REQ;
      end
      cand = idx_t'(s);
      if (req_valid[cand]) begin
        if (!found_a) begin
          found_a = 1'b1;
          idx_a   = cand;
        end else if (!found_b) begin
          found_b = 1'b1;
          idx_b   = cand;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Grant decision
  // ---------------------------------------------------------------------------
  logic conflict;
  logic gnt_a, gnt_b;

  // Same address with any write would give an undefined RAM result, so B
  // waits; no later candidate is promoted into its slot.
  assign conflict = (addr_arr[idx_a] == addr_arr[idx_b]) & (req_we[idx_a] | req_we[idx_b]);

  // Gating with rst_n keeps the RAM write enables low throughout reset.
  assign gnt_a = rst_n & found_a;
  assign gnt_b = rst_n & found_b & ~conflict;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = (gnt_a && (idx_a == idx_t'(i))) || (gnt_b && (idx_b == idx_t'(i)));
    end
  end

  // ---------------------------------------------------------------------------
  // RAM port drive
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_addr_a = '0;
    ram_data_a = '0;
    ram_we_a   = 1'b0;
    ram_addr_b = '0;
    ram_data_b = '0;
    ram_we_b   = 1'b0;
    if (gnt_a) begin
      ram_addr_a = addr_arr[idx_a];
      ram_data_a = wdata_arr[idx_a];
      ram_we_a   = req_we[idx_a];
    end
    if (gnt_b) begin
      ram_addr_b = addr_arr[idx_b];
      ram_data_b = wdata_arr[idx_b];
      ram_we_b   = req_we[idx_b];
    end
  end

  // ---------------------------------------------------------------------------
  // Pointer update: one past the last granted index
  // ---------------------------------------------------------------------------
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_b) begin
      ptr_d = next_idx(idx_b);
    end else if (gnt_a) begin
      ptr_d = next_idx(idx_a);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      rv_a_q  <= 1'b0;
      rv_b_q  <= 1'b0;
      own_a_q <= '0;
      own_b_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      rv_a_q <= gnt_a;
      rv_b_q <= gnt_b;
      if (gnt_a) begin
        own_a_q <= idx_a;
      end
      if (gnt_b) begin
        own_b_q <= idx_b;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response routing
  // ---------------------------------------------------------------------------
  // Slices with no response are driven to zero so idle and reset data is clean.
  always_comb begin
    logic hit_a, hit_b;
    rsp_valid = '0;
    rsp_rdata = '0;
    hit_a     = 1'b0;
    hit_b     = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      hit_a        = rv_a_q && (own_a_q == idx_t'(i));
      hit_b        = rv_b_q && (own_b_q == idx_t'(i));
      rsp_valid[i] = hit_a || hit_b;
      if (hit_a) begin
        rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = ram_q_a;
      end else if (hit_b) begin
        rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = ram_q_b;
      end
    end
  end

endmodule
